// File: rtl/gb_byte_host.sv
// gb_byte_host: byte-stream command parser driving a ghostbus host port.
// It takes write/read frames from rx, issues one-cycle gb_wen/gb_rstb strobes,
// and returns an ACK/NAK byte or the read data MSB first on tx.
// Only one transaction is in flight at a time.
module gb_byte_host #(
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int RD      = 8,
  parameter int IDLE_TO = 1000
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  localparam int LW = $clog2(DB + 1);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WSTB, S_RSTB, S_RWAIT, S_TX
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      bcnt_q, bcnt_d;     // bytes taken in the current field
  logic [15:0]     to_q, to_d;         // idle cycles since last accepted byte
  logic [7:0]      wcnt_q, wcnt_d;     // read-latency countdown
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rsh_q, rsh_d;       // remaining read-data bytes, MSB aligned
  logic [LW-1:0]   left_q, left_d;     // response bytes not yet handed off
  logic [7:0]      txd_q, txd_d;
  logic            txv_q, txv_d;
  logic [7:0]      err_q, err_d;
  logic            acc, snd, err_inc;

  // Accepting is gated by reset so rx_ready is low while reset is held.
  assign rx_ready = gb_rst_n &&
                    (state_q == S_IDLE || state_q == S_ADDR || state_q == S_WDATA);
  assign acc      = rx_valid && rx_ready;
  assign snd      = txv_q && tx_ready;

  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign gb_addr  = addr_q;
  assign gb_wdata = wdata_q;
  assign gb_wen   = (state_q == S_WSTB);
  assign gb_rstb  = (state_q == S_RSTB);
  assign busy     = (state_q != S_IDLE);
  assign err_cnt  = err_q;

  // Next-state and datapath: frame parsing, strobes, wait, response shifting.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsh_d   = rsh_q;
    left_d  = left_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    err_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            is_wr_d = (rx_data == OP_WR);
            bcnt_d  = '0;
            to_d    = '0;
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
            txd_d   = NAK;
            txv_d   = 1'b1;
            left_d  = LW'(1);
            state_d = S_TX;
          end
        end
      end
      S_ADDR: begin
        if (acc) begin
          addr_d = (addr_q << 8) | AW'(rx_data);
          to_d   = '0;
          if (bcnt_q == 8'(AB - 1)) begin
            bcnt_d  = '0;
            state_d = is_wr_q ? S_WDATA : S_RSTB;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end else if (to_q == 16'(IDLE_TO - 1)) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_WDATA: begin
        if (acc) begin
          wdata_d = (wdata_q << 8) | DW'(rx_data);
          to_d    = '0;
          if (bcnt_q == 8'(DB - 1)) begin
            bcnt_d  = '0;
            state_d = S_WSTB;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end else if (to_q == 16'(IDLE_TO - 1)) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_WSTB: begin
        txd_d   = ACK;
        txv_d   = 1'b1;
        left_d  = LW'(1);
        state_d = S_TX;
      end
      S_RSTB: begin
        wcnt_d  = 8'(RD);
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        // Count 1 marks cycle c0+RD: sample the bus on the edge closing it.
        if (wcnt_q == 8'd1) begin
          txd_d   = gb_rdata[DW-1 -: 8];
          rsh_d   = gb_rdata << 8;
          left_d  = LW'(DB);
          txv_d   = 1'b1;
          state_d = S_TX;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      S_TX: begin
        if (snd) begin
          if (left_q == LW'(1)) begin
            txv_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            txd_d  = rsh_q[DW-1 -: 8];
            rsh_d  = rsh_q << 8;
            left_d = left_q - LW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // State and datapath registers; reset drops any frame or response in progress.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      bcnt_q  <= '0;
      to_q    <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsh_q   <= '0;
      left_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsh_q   <= rsh_d;
      left_q  <= left_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gb_byte_host.sv
// Bench for gb_byte_host: transaction-level model (expected strobes and tx
// byte queues) checked every cycle by one compare process, plus literal pins.
module tb_gb_byte_host;
  localparam int AW = 24, DW = 32, RD = 8, TO = 16;

  logic          gb_clk = 0, gb_rst_n = 0;
  logic [7:0]    rx_data = 0;
  logic          rx_valid = 0, rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready = 0;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata, gb_rdata = 0;
  logic          gb_wen, gb_rstb, busy;
  logic [7:0]    err_cnt;

  gb_byte_host #(.AW(AW), .DW(DW), .RD(RD), .IDLE_TO(TO)) dut (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
    .gb_rdata(gb_rdata), .busy(busy), .err_cnt(err_cnt));

  always #5 gb_clk = ~gb_clk;

  int checks = 0, fails = 0;
  int cyc = 0;
  int last_acc_cyc = -100;
  int exp_err = 0;
  logic [7:0]     exp_tx[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0]  exp_rd_addr[$];
  logic [DW-1:0]  rd_vals[$];
  int             rd_c0 = -1000;
  logic [DW-1:0]  rd_val = 0;
  logic           bp_mode = 0;
  int             bp_cnt = 0;

  always @(posedge gb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink readiness: random, or one cycle in 21 under backpressure mode.
  always @(posedge gb_clk) begin
    #1;
    bp_cnt = bp_cnt + 1;
    if (bp_mode) tx_ready = (bp_cnt % 21 == 0);
    else         tx_ready = ($urandom_range(0, 3) != 0);
  end

  // Read-data model: correct value only in cycle c0+RD, all-ones next to it.
  always @(negedge gb_clk) begin
    if (gb_rst_n && gb_rstb) begin
      rd_c0 = cyc;
      rd_val = (rd_vals.size() != 0) ? rd_vals.pop_front() : '0;
    end
  end
  always @(posedge gb_clk) begin
    #1;
    if (cyc == rd_c0 + RD) gb_rdata = rd_val;
    else if (cyc == rd_c0 + RD - 1 || cyc == rd_c0 + RD + 1) gb_rdata = '1;
    else gb_rdata = $urandom;
  end

  // Per-cycle compare against the transaction model.
  logic prev_tv = 0, prev_tr = 0;
  logic [7:0] prev_td = 0;
  always @(negedge gb_clk) begin
    if (!gb_rst_n) begin
      prev_tv = 0;
    end else begin
      chk("err_cnt", err_cnt, exp_err);
      if (gb_wen && gb_rstb) chk("wen_rstb_overlap", 1, 0);
      if (gb_wen) begin
        if (exp_wr.size() == 0) chk("unexpected_wen", 1, 0);
        else begin
          logic [AW+DW-1:0] e;
          e = exp_wr.pop_front();
          chk("wen_addr", gb_addr, e[AW+DW-1:DW]);
          chk("wen_data", gb_wdata, e[DW-1:0]);
          chk("wen_latency", cyc, last_acc_cyc);
        end
      end
      if (gb_rstb) begin
        if (exp_rd_addr.size() == 0) chk("unexpected_rstb", 1, 0);
        else begin
          chk("rstb_addr", gb_addr, exp_rd_addr.pop_front());
          chk("rstb_latency", cyc, last_acc_cyc);
        end
      end
      if (prev_tv && !prev_tr) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, prev_td);
      end
      if (tx_valid) begin
        if (rx_ready) chk("rx_ready_in_tx", rx_ready, 0);
        if (tx_ready) begin
          if (exp_tx.size() == 0) chk("unexpected_tx", tx_data, 0);
          else chk("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
      prev_tv = tx_valid; prev_tr = tx_ready; prev_td = tx_data;
    end
  end

  // Drive one byte; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic acc = 0;
    rx_data = b; rx_valid = 1;
    while (!acc && n < 200) begin
      @(negedge gb_clk); acc = rx_ready;
      @(posedge gb_clk); #1; n++;
    end
    if (!acc) chk("rx_accept_timeout", 0, 1);
    last_acc_cyc = cyc;
  endtask

  task automatic gap(input int g);
    if (g > 0) begin
      rx_valid = 0;
      repeat (g) @(posedge gb_clk);
      #1;
    end
  endtask

  task automatic send_field(input logic [63:0] v, input int nbytes, input int maxgap);
    for (int i = nbytes - 1; i >= 0; i--) begin
      gap($urandom_range(0, maxgap));
      send_byte(8'((v >> (8 * i)) & 64'hFF));
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int maxgap);
    exp_wr.push_back({a, d});
    exp_tx.push_back(8'h06);
    send_byte(8'h57);
    send_field(64'(a), AW / 8, maxgap);
    send_field(64'(d), DW / 8, maxgap);
    rx_valid = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int maxgap);
    exp_rd_addr.push_back(a);
    rd_vals.push_back(d);
    for (int i = DW / 8 - 1; i >= 0; i--) exp_tx.push_back(8'((d >> (8 * i)) & 32'hFF));
    send_byte(8'h52);
    send_field(64'(a), AW / 8, maxgap);
    rx_valid = 0;
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_tx.push_back(8'h15);
    send_byte(b);
    rx_valid = 0;
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tx_valid || exp_tx.size() != 0) && n < 3000) begin
      @(posedge gb_clk); #1; n++;
    end
    if (n >= 3000) chk("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_outs", {gb_addr, gb_wdata, gb_wen, gb_rstb, err_cnt, busy}, 0);
    repeat (3) @(posedge gb_clk);
    #1 gb_rst_n = 1;
    #1 chk("rel_rx_ready", rx_ready, 1);
    @(posedge gb_clk); #1;

    // Directed write, rx_valid held high throughout
    do_write(24'h123456, 32'hDEADBEEF, 0);
    wait_idle();
    chk("wr_addr_lit", gb_addr, 24'h123456);
    chk("wr_data_lit", gb_wdata, 32'hDEADBEEF);
    chk("wr_busy_done", busy, 0);

    // Directed read with literal response bytes
    exp_rd_addr.push_back(24'h000010);
    rd_vals.push_back(32'hCAFE0042);
    exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h42);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    rx_valid = 0;
    wait_idle();

    // Bad opcode
    do_bad(8'h41);
    wait_idle();
    chk("bad_err_lit", err_cnt, 1);

    // Timeout in ADDR: abort exactly on the TO-th idle cycle
    send_byte(8'h57); send_byte(8'h12);
    rx_valid = 0;
    repeat (TO - 1) @(posedge gb_clk);
    #1 chk("to_busy_before", busy, 1);
    @(posedge gb_clk); #1;
    exp_err++;
    chk("to_busy_after", busy, 0);
    chk("to_err_lit", err_cnt, 2);
    do_read(24'hABCDEF, $urandom, 2);
    wait_idle();

    // Backpressure read: 20 stalled cycles between bytes
    bp_mode = 1;
    do_read(24'h00F00D, 32'h89ABCDEF, 0);
    wait_idle();
    bp_mode = 0;

    // Randomised frames
    for (int k = 0; k < 40; k++) begin
      int t = $urandom_range(0, 9);
      if (t < 4) do_write(AW'($urandom), $urandom, 3);
      else if (t < 8) do_read(AW'($urandom), $urandom, 3);
      else begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_bad(b);
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
      else begin
        // back-to-back: wait only for the response to finish
        int n = 0;
        while (busy && n < 3000) begin @(posedge gb_clk); #1; n++; end
      end
    end
    wait_idle();

    // Reset during RWAIT
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h02);
    exp_rd_addr.push_back(24'h010203);
    rd_vals.push_back(32'h11223344);
    send_byte(8'h03);
    rx_valid = 0;
    repeat (3) @(posedge gb_clk);
    #1 gb_rst_n = 0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_outs", {gb_addr, gb_wdata, gb_wen, gb_rstb, err_cnt, busy}, 0);
    exp_tx.delete(); exp_wr.delete(); exp_rd_addr.delete(); rd_vals.delete();
    exp_err = 0;
    repeat (2) @(posedge gb_clk);
    #1 gb_rst_n = 1;
    repeat (30) @(posedge gb_clk);
    #1;
    do_write(24'h0A0B0C, 32'h01020304, 1);
    wait_idle();
    chk("post_rst_addr", gb_addr, 24'h0A0B0C);
    chk("post_rst_data", gb_wdata, 32'h01020304);

    // Saturation of err_cnt
    for (int k = 0; k < 256; k++) begin
      do_bad(8'hFF);
      wait_idle();
    end
    chk("err_sat_lit", err_cnt, 255);

    repeat (5) @(posedge gb_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gb_byte_host.md
Name: gb_byte_host

Overview:
- Byte-stream host master that drives the ghostbus host port of a ghostbus top level.
- Sits directly upstream of the decoded register space.
- Parses framed command bytes from a serial/FIFO source, issues single-cycle write or read strobes on the ghostbus, and returns an ack byte or read data as a byte stream.
- One outstanding transaction at a time.

Parameters:
- AW, 24, ghostbus address width; multiple of 8; sent as AW/8 bytes, MSB first.
- DW, 32, ghostbus data width; multiple of 8; sent/returned as DW/8 bytes, MSB first.
- RD, 8, cycles from the gb_rstb cycle to the gb_rdata sample; range 1..255.
- IDLE_TO, 1000, max cycles between accepted bytes inside a partial frame before abort; range 2..65535.

Ports:
- gb_clk, in, 1, bus clock; all logic on rising edge.
- gb_rst_n, in, 1, asynchronous active-low reset.
- rx_data, in, 8, command byte.
- rx_valid, in, 1, rx_data valid.
- rx_ready, out, 1, block accepts rx_data this cycle.
- tx_data, out, 8, response byte.
- tx_valid, out, 1, tx_data valid.
- tx_ready, in, 1, sink accepts tx_data.
- gb_addr, out, AW, ghostbus address.
- gb_wdata, out, DW, ghostbus write data.
- gb_wen, out, 1, write strobe, one cycle.
- gb_rstb, out, 1, read strobe, one cycle.
- gb_rdata, in, DW, ghostbus read data.
- busy, out, 1, high whenever state != IDLE.
- err_cnt, out, 8, saturating count of bad opcodes plus timeouts.

Behaviour:
- Reset, asynchronous on gb_rst_n low:
  - State goes to IDLE.
  - gb_addr, gb_wdata, gb_wen, gb_rstb, tx_data, tx_valid and err_cnt go to 0.
  - rx_ready goes to 0 while reset is asserted and returns to 1 on the first cycle after release.
  - Any partial frame or pending response is discarded.
  - A strobe in flight is cut; no further strobe is issued.
- A byte is accepted on an edge where rx_valid && rx_ready.
- rx_ready is 1 only in IDLE, ADDR and WDATA.
- A byte is sent on an edge where tx_valid && tx_ready. tx_data must not change while tx_valid=1 && tx_ready=0.
- Frames:
  - Write: 0x57, then AW/8 address bytes, then DW/8 data bytes.
  - Read: 0x52, then AW/8 address bytes.
- State machine:
  - IDLE:
    - Accepting 0x57 or 0x52 latches the opcode and goes to ADDR.
    - Accepting any other byte increments err_cnt (saturating at 255), loads NAK 0x15 and goes to TX.
  - ADDR: each accepted byte shifts into gb_addr from the LSB side. After byte AW/8 is accepted: a write goes to WDATA; a read goes to RSTB.
  - WDATA: each accepted byte shifts into gb_wdata. After byte DW/8 is accepted, go to WSTB.
  - WSTB:
    - gb_wen=1 for exactly this one cycle; gb_addr and gb_wdata are already final.
    - Next state is TX with ACK 0x06 loaded.
    - Latency is 1 cycle from acceptance of the last data byte to gb_wen.
  - RSTB: gb_rstb=1 for exactly this one cycle, cycle c0. Load the wait counter with RD and go to RWAIT.
  - RWAIT:
    - Counter decrements once per cycle.
    - gb_rdata is captured into a shift register on the edge ending cycle c0+RD.
    - Next state is TX with the first byte (MSB) loaded and DW/8 bytes pending.
  - TX:
    - tx_valid=1 with the current byte.
    - On each handshake, load the next byte. After the last handshake, go to IDLE with tx_valid=0 on the following cycle.
    - A single-byte response (ACK or NAK) ends after one handshake.
- Timeout:
  - In ADDR and WDATA, a counter resets on each accepted byte and increments otherwise.
  - When it reaches IDLE_TO: abort to IDLE, increment err_cnt, send no response, issue no strobe. gb_addr and gb_wdata keep their partially shifted contents.
  - No timeout applies in TX; backpressure may stall indefinitely.
- gb_addr and gb_wdata hold their values between transactions. gb_wen and gb_rstb are never high together and never high outside WSTB/RSTB.
- Back-to-back: a new opcode may be accepted the cycle after the final TX handshake, since IDLE has rx_ready=1.

Test Plan:
- Write: send 57 12 34 56 DE AD BE EF with rx_valid held high.
  - gb_wen is high for exactly 1 cycle, 1 cycle after EF is accepted, with gb_addr=0x123456 and gb_wdata=0xDEADBEEF.
  - tx emits 06. busy returns to 0 after the ACK.
- Read, RD=8: send 52 00 00 10; gb_rdata model returns 0xCAFE0042 exactly 8 cycles after gb_rstb.
  - gb_rstb is high for 1 cycle.
  - tx emits CA FE 00 42 in order.
  - Also drive gb_rdata=0xFFFFFFFF at c0+RD-1 and c0+RD+1 only, and confirm those values are not captured.
- Bad opcode: send 41.
  - tx emits 15 and err_cnt=1.
  - Send 256 bad opcodes; err_cnt saturates at 255.
- Timeout, IDLE_TO=16: send 57 12 then nothing for 16 cycles.
  - State returns to IDLE, err_cnt increments, and no gb_wen or tx output occurs.
  - A following complete read frame works normally.
- TX backpressure: during a read response, hold tx_ready=0 for 20 cycles between bytes.
  - tx_data stays stable, rx_ready stays 0, no bytes are lost or duplicated.
- Reset mid-read: assert gb_rst_n=0 during RWAIT.
  - All outputs are 0 immediately (asynchronous).
  - After release, no tx bytes appear and the next write frame completes correctly.
